// File: rtl/button_event_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_event_decoder_pkg
// Description : Shared state encoding and timing helpers for the button
//               event decoder and its millisecond prescaler.
// Revision    : 1.0 - initial release
// ============================================================================
package button_event_decoder_pkg;

    // Decoder states. ARM waits for a sampled release after reset.
    typedef enum logic [1:0] {
        ARM       = 2'd0,
        IDLE      = 2'd1,
        PRESSED   = 2'd2,
        LONG_HELD = 2'd3
    } state_t;

    localparam int c_HZ_PER_KHZ = 1000;

    // Clock cycles in one millisecond.
    function automatic int ticks_per_ms(input int clock_freq_hz);
        return clock_freq_hz / c_HZ_PER_KHZ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : button_event_decoder_if
// Description : Button level input and decoded event outputs. The master
//               modport is the decoder; the slave modport is the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_event_decoder_if #(
    parameter int HELD_MS_WIDTH = 16
);
    logic                     btn_level;
    logic                     press_pulse;
    logic                     release_pulse;
    logic                     click_pulse;
    logic                     long_pulse;
    logic                     repeat_pulse;
    logic                     held;
    logic [HELD_MS_WIDTH-1:0] held_ms;

    modport master (
        input  btn_level,
        output press_pulse, release_pulse, click_pulse, long_pulse,
               repeat_pulse, held, held_ms
    );

    modport slave (
        output btn_level,
        input  press_pulse, release_pulse, click_pulse, long_pulse,
               repeat_pulse, held, held_ms
    );
endinterface
`default_nettype wire

// File: rtl/button_event_decoder_ms_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : ms_tick_gen
// Description : Free-running prescaler with synchronous clear. o_tick is high
//               for the one cycle in which the counter sits at its last value,
//               so a clear on edge N places the next tick on edge
//               N + TICKS_PER_MS.
// Revision    : 1.0 - initial release
// ============================================================================
module ms_tick_gen #(
    parameter int TICKS_PER_MS = 100_000
) (
    input  wire logic clk,
    input  wire logic reset_n,
    input  wire logic i_clear,
    output logic      o_tick
);
    localparam int              c_CNT_W = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TICKS_PER_MS - 1);

    logic [c_CNT_W-1:0] r_count;

    // Count 0..TICKS_PER_MS-1, wrapping on the last value or restarting on clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_clear || (r_count == c_LAST)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    // A clear on the wrap edge restarts the period, so that tick is suppressed.
    assign o_tick = (r_count == c_LAST) && !i_clear;

endmodule
`default_nettype wire

// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : button_event_decoder
// Description : Turns a debounced button level into registered one-cycle
//               press / release / click / long / repeat pulses, plus a held
//               level and a saturating held-time in milliseconds.
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int CLOCK_FREQ_HZ = 100_000_000,
    parameter int LONG_PRESS_MS = 1000,
    parameter int REPEAT_MS     = 200,
    parameter int HELD_MS_WIDTH = 16
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    button_event_decoder_if.master bus
);
    localparam int c_TICKS  = ticks_per_ms(CLOCK_FREQ_HZ);
    localparam int c_LONG_W = $clog2(LONG_PRESS_MS + 1);
    localparam int c_REP_W  = $clog2(REPEAT_MS + 1);

    localparam logic [c_LONG_W-1:0] c_LONG_LAST = c_LONG_W'(LONG_PRESS_MS - 1);
    localparam logic [c_REP_W-1:0]  c_REP_LAST  = c_REP_W'(REPEAT_MS - 1);

    state_t                   r_state, w_state_nxt;
    logic [c_LONG_W-1:0]      r_long_cnt, w_long_cnt_nxt;
    logic [c_REP_W-1:0]       r_rep_cnt, w_rep_cnt_nxt;
    logic [HELD_MS_WIDTH-1:0] r_held_ms, w_held_ms_nxt, w_held_ms_inc;
    logic                     r_press, r_release, r_click, r_long, r_repeat, r_held;
    logic                     w_press, w_release, w_click, w_long, w_repeat, w_held;
    logic                     w_tick, w_tick_clr;
    logic                     w_btn;

    assign w_btn = bus.btn_level;

    ms_tick_gen #(
        .TICKS_PER_MS (c_TICKS)
    ) u_ms_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_tick_clr),
        .o_tick  (w_tick)
    );

    assign w_held_ms_inc = (&r_held_ms) ? r_held_ms : r_held_ms + HELD_MS_WIDTH'(1);

    // State, counters and every output are registered together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ARM;
            r_long_cnt <= '0;
            r_rep_cnt  <= '0;
            r_held_ms  <= '0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_click    <= 1'b0;
            r_long     <= 1'b0;
            r_repeat   <= 1'b0;
            r_held     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_long_cnt <= w_long_cnt_nxt;
            r_rep_cnt  <= w_rep_cnt_nxt;
            r_held_ms  <= w_held_ms_nxt;
            r_press    <= w_press;
            r_release  <= w_release;
            r_click    <= w_click;
            r_long     <= w_long;
            r_repeat   <= w_repeat;
            r_held     <= w_held;
        end
    end

    // Next state and next-cycle pulses; a release always beats a same-edge
    // long threshold or repeat.
    always_comb begin
        w_state_nxt    = r_state;
        w_long_cnt_nxt = r_long_cnt;
        w_rep_cnt_nxt  = r_rep_cnt;
        w_held_ms_nxt  = r_held_ms;
        w_tick_clr     = 1'b0;
        w_press        = 1'b0;
        w_release      = 1'b0;
        w_click        = 1'b0;
        w_long         = 1'b0;
        w_repeat       = 1'b0;

        case (r_state)
            ARM: begin
                if (!w_btn) begin
                    w_state_nxt = IDLE;
                end
            end

            IDLE: begin
                if (w_btn) begin
                    w_state_nxt    = PRESSED;
                    w_press        = 1'b1;
                    w_held_ms_nxt  = '0;
                    w_long_cnt_nxt = '0;
                    w_tick_clr     = 1'b1;
                end
            end

            PRESSED: begin
                if (w_tick) begin
                    w_held_ms_nxt  = w_held_ms_inc;
                    w_long_cnt_nxt = r_long_cnt + c_LONG_W'(1);
                end
                if (!w_btn) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                    w_click     = 1'b1;
                end else if (w_tick && (r_long_cnt == c_LONG_LAST)) begin
                    w_state_nxt   = LONG_HELD;
                    w_long        = 1'b1;
                    w_rep_cnt_nxt = '0;
                end
            end

            LONG_HELD: begin
                if (w_tick) begin
                    w_held_ms_nxt = w_held_ms_inc;
                end
                if (!w_btn) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                end else if (w_tick) begin
                    if (r_rep_cnt == c_REP_LAST) begin
                        w_repeat      = 1'b1;
                        w_rep_cnt_nxt = '0;
                    end else begin
                        w_rep_cnt_nxt = r_rep_cnt + c_REP_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = ARM;
            end
        endcase

        w_held = (w_state_nxt == PRESSED) || (w_state_nxt == LONG_HELD);
    end

    assign bus.press_pulse   = r_press;
    assign bus.release_pulse = r_release;
    assign bus.click_pulse   = r_click;
    assign bus.long_pulse    = r_long;
    assign bus.repeat_pulse  = r_repeat;
    assign bus.held          = r_held;
    assign bus.held_ms       = r_held_ms;

endmodule
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_decoder
// Description : Directed bench for button_event_decoder at 10 clocks per ms,
//               long press 5 ms, repeat 2 ms, 4-bit held_ms.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_decoder;
    localparam int CLOCK_FREQ_HZ = 10_000;
    localparam int LONG_PRESS_MS = 5;
    localparam int REPEAT_MS     = 2;
    localparam int HELD_MS_WIDTH = 4;

    logic clk;
    logic reset_n;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations from the last run_hold; cycle c is sampled after edge c-1.
    int press_n, press_cyc, rel_n, rel_cyc, click_n, click_cyc;
    int long_n, long_cyc, rep_n, rep_first, rep_last;
    int rel_held_ms, mid_held_ms, mid_held, after_held;

    button_event_decoder_if #(.HELD_MS_WIDTH(HELD_MS_WIDTH)) bif ();

    button_event_decoder #(
        .CLOCK_FREQ_HZ (CLOCK_FREQ_HZ),
        .LONG_PRESS_MS (LONG_PRESS_MS),
        .REPEAT_MS     (REPEAT_MS),
        .HELD_MS_WIDTH (HELD_MS_WIDTH)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] outs();
        return {bif.press_pulse, bif.release_pulse, bif.click_pulse, bif.long_pulse,
                bif.repeat_pulse, bif.held, bif.held_ms};
    endfunction

    // Press on edge 0, hold through edge h-1, release sampled on edge h.
    task automatic run_hold(input int h);
        press_n = 0; press_cyc = -1; rel_n = 0; rel_cyc = -1; click_n = 0; click_cyc = -1;
        long_n = 0; long_cyc = -1; rep_n = 0; rep_first = -1; rep_last = -1;
        rel_held_ms = -1; mid_held_ms = -1; mid_held = -1; after_held = -1;
        bif.btn_level = 1'b1;
        for (int k = 0; k < h + 4; k++) begin
            if (k == h) bif.btn_level = 1'b0;
            @(posedge clk); #1;
            if (bif.press_pulse) begin press_n++; if (press_cyc < 0) press_cyc = k + 1; end
            if (bif.long_pulse) begin long_n++; if (long_cyc < 0) long_cyc = k + 1; end
            if (bif.repeat_pulse) begin rep_n++; if (rep_first < 0) rep_first = k + 1; rep_last = k + 1; end
            if (bif.release_pulse) begin rel_n++; rel_cyc = k + 1; rel_held_ms = int'(bif.held_ms); end
            if (bif.click_pulse) begin click_n++; click_cyc = k + 1; end
            if (k + 1 == h) begin mid_held = int'(bif.held); mid_held_ms = int'(bif.held_ms); end
            if (k + 1 == h + 2) after_held = int'(bif.held);
        end
    endtask

    task automatic test_reset();
        int pulses;
        int held_seen;
        reset_n = 1'b0;
        bif.btn_level = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (outs() !== 11'd0) $display("FAIL reset_outputs got %b want 0", outs());
        else n_pass++;
        reset_n = 1'b1;
        pulses = 0; held_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (bif.press_pulse | bif.release_pulse | bif.click_pulse | bif.long_pulse | bif.repeat_pulse)
                pulses++;
            if (bif.held) held_seen++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL arm_no_pulse got %0d pulse cycles want 0", pulses);
        else n_pass++;
        n_checks++;
        if (held_seen !== 0) $display("FAIL arm_held got %0d held cycles want 0", held_seen);
        else n_pass++;
        bif.btn_level = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_arm_press();
        run_hold(20);
        n_checks++;
        if (press_cyc !== 1 || press_n !== 1)
            $display("FAIL arm_press got cyc %0d n %0d want cyc 1 n 1", press_cyc, press_n);
        else n_pass++;
    endtask

    task automatic test_click();
        run_hold(30);
        n_checks++;
        if (press_cyc !== 1) $display("FAIL click_press got %0d want 1", press_cyc);
        else n_pass++;
        n_checks++;
        if (rel_cyc !== 31 || rel_n !== 1) $display("FAIL click_release got cyc %0d n %0d want 31 1", rel_cyc, rel_n);
        else n_pass++;
        n_checks++;
        if (click_cyc !== 31 || click_n !== 1) $display("FAIL click_click got cyc %0d n %0d want 31 1", click_cyc, click_n);
        else n_pass++;
        n_checks++;
        if (rel_held_ms !== 3) $display("FAIL click_held_ms got %0d want 3", rel_held_ms);
        else n_pass++;
        n_checks++;
        if (long_n !== 0 || rep_n !== 0) $display("FAIL click_no_long got long %0d rep %0d want 0 0", long_n, rep_n);
        else n_pass++;
        n_checks++;
        if (mid_held !== 1 || after_held !== 0) $display("FAIL click_held got %0d/%0d want 1/0", mid_held, after_held);
        else n_pass++;
    endtask

    task automatic test_long();
        run_hold(100);
        n_checks++;
        if (long_cyc !== 51 || long_n !== 1) $display("FAIL long_pulse got cyc %0d n %0d want 51 1", long_cyc, long_n);
        else n_pass++;
        n_checks++;
        if (rep_n !== 2 || rep_first !== 71 || rep_last !== 91)
            $display("FAIL long_repeat got n %0d first %0d last %0d want 2 71 91", rep_n, rep_first, rep_last);
        else n_pass++;
        n_checks++;
        if (rel_cyc !== 101 || click_n !== 0)
            $display("FAIL long_release got rel %0d click %0d want 101 0", rel_cyc, click_n);
        else n_pass++;
        n_checks++;
        if (mid_held_ms !== 9 || rel_held_ms !== 10)
            $display("FAIL long_held_ms got %0d/%0d want 9/10", mid_held_ms, rel_held_ms);
        else n_pass++;
    endtask

    task automatic test_release_at_threshold();
        run_hold(50);
        n_checks++;
        if (long_n !== 0) $display("FAIL thresh_long got %0d want 0", long_n);
        else n_pass++;
        n_checks++;
        if (rel_cyc !== 51 || click_cyc !== 51)
            $display("FAIL thresh_release got rel %0d click %0d want 51 51", rel_cyc, click_cyc);
        else n_pass++;
        n_checks++;
        if (rel_held_ms !== 5) $display("FAIL thresh_held_ms got %0d want 5", rel_held_ms);
        else n_pass++;
    endtask

    task automatic test_saturate();
        run_hold(200);
        n_checks++;
        if (mid_held_ms !== 15 || rel_held_ms !== 15)
            $display("FAIL sat_held_ms got %0d/%0d want 15/15", mid_held_ms, rel_held_ms);
        else n_pass++;
        n_checks++;
        if (rep_n !== 7 || rep_first !== 71 || rep_last !== 191)
            $display("FAIL sat_repeat got n %0d first %0d last %0d want 7 71 191", rep_n, rep_first, rep_last);
        else n_pass++;
        n_checks++;
        if (rel_n !== 1 || click_n !== 0 || rel_cyc !== 201)
            $display("FAIL sat_release got rel %0d@%0d click %0d want 1@201 0", rel_n, rel_cyc, click_n);
        else n_pass++;
    endtask

    task automatic test_reset_mid_press();
        int long_seen;
        int pulses;
        long_seen = 0;
        bif.btn_level = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (bif.long_pulse) long_seen++;
        end
        n_checks++;
        if (long_seen !== 1 || bif.held !== 1'b1)
            $display("FAIL midrst_pre got long %0d held %0b want 1 1", long_seen, bif.held);
        else n_pass++;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (outs() !== 11'd0) $display("FAIL midrst_outputs got %b want 0", outs());
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bif.press_pulse | bif.release_pulse | bif.click_pulse | bif.long_pulse |
                bif.repeat_pulse | bif.held)
                pulses++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL midrst_quiet got %0d active cycles want 0", pulses);
        else n_pass++;
        bif.btn_level = 1'b0;
        @(posedge clk); #1;
        run_hold(10);
        n_checks++;
        if (press_cyc !== 1 || click_cyc !== 11)
            $display("FAIL midrst_repress got press %0d click %0d want 1 11", press_cyc, click_cyc);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_arm_press();
        test_click();
        test_long();
        test_release_at_threshold();
        test_saturate();
        test_reset_mid_press();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
Consumes the debounced, clock-synchronous button level and converts it into one-cycle event pulses: press, release, short click, long press, and auto-repeat while held. It also reports how long the button has been held. Sits between the per-button debouncer and the image-processor control FSM, which uses click to step filter mode and repeat to ramp parameters.

Parameters:
CLOCK_FREQ_HZ, 100_000_000, system clock frequency; must be at least 1000 and a multiple of 1000.
LONG_PRESS_MS, 1000, hold time that qualifies a long press; must be at least 1.
REPEAT_MS, 200, auto-repeat period after a long press; must be at least 1.
HELD_MS_WIDTH, 16, width of held_ms; saturating.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
btn_level  in  1  debounced button level, active high, already synchronous to clk.
press_pulse  out  1  one-cycle pulse on a qualified press.
release_pulse  out  1  one-cycle pulse on release of a qualified press.
click_pulse  out  1  one-cycle pulse on release before the long threshold.
long_pulse  out  1  one-cycle pulse when the hold reaches LONG_PRESS_MS.
repeat_pulse  out  1  one-cycle pulse every REPEAT_MS while in the long-hold state.
held  out  1  level; high in PRESSED and LONG_HELD.
held_ms  out  HELD_MS_WIDTH  milliseconds held in the current press; saturates at all-ones.

Behaviour:
- Clocking and reset: one clock domain. Asynchronous active-low reset drives every output to 0, state to ARM, and clears all counters.
- Registered outputs: every output is a register. Each pulse is high for exactly the one cycle after the edge where its condition is sampled.
- ms tick: prescaler counts 0..CLOCK_FREQ_HZ/1000-1 and emits a tick on wrap. It is forced to 0 on the edge where a press is accepted, so ticks fall exactly 1 ms, 2 ms, ... after that press edge.
- ARM (reset state): ignores btn_level high. A button held through reset never produces press. Moves to IDLE on the first edge that samples btn_level=0. No outputs fire.
- IDLE -> PRESSED on btn_level=1:
  - press_pulse=1
  - held_ms cleared to 0
  - prescaler cleared
- PRESSED, on each tick:
  - held_ms increments, saturating.
  - When the tick takes the ms count to LONG_PRESS_MS: long_pulse=1, repeat counter cleared, state -> LONG_HELD.
- PRESSED, on btn_level=0: release_pulse=1, click_pulse=1, state -> IDLE.
- LONG_HELD, on each tick: held_ms increments, saturating. Every REPEAT_MS ticks, repeat_pulse=1; the first repeat comes REPEAT_MS after long_pulse.
- LONG_HELD, on btn_level=0: release_pulse=1, no click, state -> IDLE.
- Simultaneous events:
  - Release sampled on the same edge as the long-threshold tick: release wins. click_pulse and release_pulse fire; long_pulse does not.
  - Release on the same edge as a repeat tick: release_pulse only.
- Long-threshold decision: uses an internal counter sized $clog2(LONG_PRESS_MS+1), independent of held_ms saturation.
- held_ms in IDLE: holds the last value until the next press.
- Reset mid-press: immediate return to ARM with all outputs 0. The next press requires a sampled release first.

Decomposition:
- Shared package: state encoding (ARM, IDLE, PRESSED, LONG_HELD) and ticks-per-ms constant derivation.
- One sub-module: ms_tick_gen, a prescaler with a synchronous clear input and a single-cycle tick output. It is reusable by other timing blocks.

Test Plan:
Bench parameters: CLOCK_FREQ_HZ=10_000 (10 clk/ms), LONG_PRESS_MS=5, REPEAT_MS=2, HELD_MS_WIDTH=4. Press edge is cycle 0.
1. reset_n released with btn_level=1 for 40 cycles -> no pulses, held=0. btn_level=0 then 1 -> press_pulse high exactly 1 cycle after the accepting edge.
2. Press held 30 cycles -> press_pulse at cycle 1. On release: release_pulse=1 and click_pulse=1 one cycle after the falling sample, held_ms=3, long_pulse never asserted.
3. Press held 100 cycles -> long_pulse at cycle 51, repeat_pulse at cycles 71 and 91. Release gives release_pulse only, no click_pulse.
4. btn_level sampled 0 on the edge at cycle 50, the long threshold -> click_pulse and release_pulse fire, long_pulse stays 0.
5. Hold 200 cycles -> held_ms counts to 15 and stays 15. Repeats keep firing every 20 cycles.
6. Assert reset_n low at cycle 60 of a long hold, deassert with btn_level still 1 -> outputs 0 immediately. No pulses until release followed by a new press.
